fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be:
- PC_W, default 8: program-counter and memory-address width.
- IW, default 16: instruction width.
- RESET_PC, default 0: fetch address after reset.
- TIMEOUT, default 15: maximum wait cycles for mem_ack, minimum 1.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- mem_req  out  1  instruction read request.
- mem_addr  out  PC_W  read address.
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  IW  read data.
- ir  out  IW  held instruction.
- ir_valid  out  1  ir holds an unconsumed instruction.
- ir_ready  in  1  decoder consumes ir this cycle.
- pc  out  PC_W  address of the instruction in ir.
- link  out  PC_W  pc+1, the return address.
- br_valid  in  1  the instruction in ir is a branch being resolved.
- br_cond  in  3  condition code.
- br_status  in  3  flags {N,V,Z}.
- br_tsel  in  1  target select: 0 = pc-relative, 1 = register.
- br_offset  in  PC_W  signed offset.
- br_reg  in  PC_W  register target.
- br_taken  out  1  one-cycle redirect pulse.
- err  out  1  sticky memory-timeout flag.

Function
REQ-003 FSM states SHALL be FETCH, WAIT, FULL and ERR; the block SHALL allow at most one outstanding read.
REQ-004 FETCH:
- mem_req=1 and mem_addr=fpc, where fpc is the internal next-fetch address.
- The next state is WAIT unless mem_ack=1 in the same cycle; in that case the FETCH->WAIT step is skipped and the capture of REQ-006 applies.
REQ-005 WAIT:
- mem_req stays 1 and mem_addr stays fpc until mem_ack.
- A wait counter increments each WAIT cycle.
- On reaching TIMEOUT wait cycles without mem_ack, the FSM SHALL go to ERR.
REQ-006 Capture, on the edge with mem_req=1 and mem_ack=1:
- ir<=mem_rdata, pc<=fpc, fpc<=fpc+1 (mod 2^PC_W, wraps from 2^PC_W-1 to 0).
- ir_valid<=1, wait counter cleared, next state FULL.
REQ-007 FULL:
- mem_req=0.
- ir, pc and ir_valid are held until ir_ready=1.
- When ir_ready=1, ir_valid<=0 and the next state is FETCH.
- Fetch latency: capture to next mem_req is exactly 1 cycle after consume.
REQ-008 Branch condition, evaluated only in FULL with ir_ready=1 and br_valid=1 (N=br_status[2], V=br_status[1], Z=br_status[0]):
- 000 and 111: always taken.
- 001: Z.
- 010: !Z.
- 011: N!=V.
- 100: (N!=V)|Z.
- All other codes: not taken.
REQ-009 Taken branch:
- fpc <= br_tsel ? br_reg : pc+1+br_offset (mod 2^PC_W, offset sign-extended within PC_W).
- br_taken=1 for exactly that cycle.
- br_valid with a condition that is false leaves fpc unchanged.
REQ-010 br_valid is ignored in FETCH, WAIT, ERR, or in FULL with ir_ready=0; br_taken SHALL be 0 in all of these.
REQ-011 br_taken SHALL be combinational from the current-cycle inputs; all other outputs SHALL be registered or state-decoded.
REQ-012 link SHALL equal pc+1 mod 2^PC_W at all times.
REQ-013 ERR:
- mem_req=0, ir_valid=0, err=1.
- Stays in ERR until reset; mem_ack and ir_ready are ignored.
REQ-014 mem_ack arriving in FULL or ERR SHALL be ignored (no capture, no state change).

Reset
REQ-015 reset=0 SHALL asynchronously force the outputs and internal state:
- State FETCH, fpc=RESET_PC, pc=RESET_PC, ir=0, ir_valid=0.
- err=0, wait counter=0.
- br_taken=0 while reset=0.
REQ-016 Reset asserted mid-WAIT or in FULL SHALL abandon the in-flight read and the held instruction.
REQ-017 First mem_req after reset deassertion: mem_req=1 with mem_addr=RESET_PC in the first cycle after reset rises.

Verification
REQ-018 Reset then mem_ack held 1 with rdata=16'hA001 and ir_ready=1 -> mem_req at addr 0, then captures at 0, 1, 2 on alternate cycles; pc=0 with ir=A001 on first capture; link=1.
REQ-019 pc=8'h10, Z=1, br_cond=001, br_tsel=0, br_offset=8'hFE -> br_taken=1; next mem_addr=8'h0F. Same stimulus with Z=0 -> br_taken=0; next mem_addr=8'h11.
REQ-020 br_cond=000, br_tsel=1, br_reg=8'h42 -> next mem_addr=8'h42. br_cond=011 with N=1, V=1 -> not taken.
REQ-021 mem_ack withheld, TIMEOUT=15 -> err=1 and mem_req=0 after 15 WAIT cycles; late mem_ack ignored; reset pulse -> err=0 and fetch restarts at RESET_PC.
REQ-022 fpc=8'hFF capture -> pc=FF, link=00, next mem_addr=00. ir_ready=0 for 5 cycles in FULL -> ir, pc and ir_valid stable, mem_req=0, br_valid ignored.
REQ-023 Reset asserted during WAIT with mem_ack=1 in the same cycle -> no capture; ir_valid=0; mem_addr=RESET_PC after release.

Source files
------------

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: fetches into a one-entry
// instruction register and redirects the fetch address on resolved branches.
module fetch_unit #(
  parameter int              PC_W     = 8,
  parameter int              IW       = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 15
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [IW-1:0]   mem_rdata,
  output logic [IW-1:0]   ir,
  output logic            ir_valid,
  input  logic            ir_ready,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] link,
  input  logic            br_valid,
  input  logic [2:0]      br_cond,
  input  logic [2:0]      br_status,
  input  logic            br_tsel,
  input  logic [PC_W-1:0] br_offset,
  input  logic [PC_W-1:0] br_reg,
  output logic            br_taken,
  output logic            err
);

  // Handshakes: a read transfers on any rising edge where mem_req && mem_ack;
  // the instruction is consumed on any rising edge where ir_valid && ir_ready.
  // Neither side may withdraw once raised; mem_req stays up with a stable
  // mem_addr until acked, ir/pc stay stable while ir_valid && !ir_ready.

  typedef enum logic [1:0] {FETCH, WAIT, FULL, ERR} state_t;

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t          state, state_nxt;
  logic [PC_W-1:0] fpc;
  logic [CW-1:0]   wait_cnt;
  logic            capture, consume, cnt_inc, cond_true;
  logic [PC_W-1:0] br_target;
  logic            flag_n, flag_v, flag_z;

  assign flag_n = br_status[2];
  assign flag_v = br_status[1];
  assign flag_z = br_status[0];

  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      3'b000, 3'b111: cond_true = 1'b1;
      3'b001:         cond_true = flag_z;
      3'b010:         cond_true = !flag_z;
      3'b011:         cond_true = flag_n ^ flag_v;
      3'b100:         cond_true = (flag_n ^ flag_v) | flag_z;
      default:        cond_true = 1'b0;
    endcase
  end

  // Offset is the full PC_W width, so modular addition already sign-extends.
  assign br_target = br_tsel ? br_reg : (link + br_offset);

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    consume   = 1'b0;
    cnt_inc   = 1'b0;
    mem_req   = 1'b0;
    br_taken  = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          capture   = 1'b1;
          state_nxt = FULL;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          capture   = 1'b1;
          state_nxt = FULL;
        end else begin
          cnt_inc = 1'b1;
          if (wait_cnt == CW'(TIMEOUT - 1)) state_nxt = ERR;
        end
      end
      FULL: begin
        if (ir_ready) begin
          consume   = 1'b1;
          br_taken  = br_valid & cond_true;
          state_nxt = FETCH;
        end
      end
      ERR: begin
        state_nxt = ERR;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      fpc      <= RESET_PC;
      pc       <= RESET_PC;
      ir       <= '0;
      ir_valid <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        ir       <= mem_rdata;
        pc       <= fpc;
        fpc      <= fpc + PC_W'(1);
        ir_valid <= 1'b1;
        wait_cnt <= '0;
      end else if (cnt_inc) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (consume) begin
        ir_valid <= 1'b0;
        if (br_taken) fpc <= br_target;
      end
    end
  end

  assign mem_addr = fpc;
  assign link     = pc + PC_W'(1);
  assign err      = (state == ERR);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: an instruction-stream model
// predicts the fetch address sequence and a negedge monitor compares.
module tb_fetch_unit;
  localparam int              PC_W     = 8;
  localparam int              IW       = 16;
  localparam logic [PC_W-1:0] RESET_PC = 8'h00;
  localparam int              TIMEOUT  = 15;
  localparam int              W        = PC_W + IW;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            mem_req;
  logic [PC_W-1:0] mem_addr;
  logic            mem_ack = 1'b0;
  logic [IW-1:0]   mem_rdata = '0;
  logic [IW-1:0]   ir;
  logic            ir_valid;
  logic            ir_ready = 1'b0;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] link;
  logic            br_valid = 1'b0;
  logic [2:0]      br_cond = '0;
  logic [2:0]      br_status = '0;
  logic            br_tsel = 1'b0;
  logic [PC_W-1:0] br_offset = '0;
  logic [PC_W-1:0] br_reg = '0;
  logic            br_taken;
  logic            err;

  fetch_unit #(.PC_W(PC_W), .IW(IW), .RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready), .pc(pc), .link(link),
    .br_valid(br_valid), .br_cond(br_cond), .br_status(br_status), .br_tsel(br_tsel),
    .br_offset(br_offset), .br_reg(br_reg), .br_taken(br_taken), .err(err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0]  exp_q[$];       // head = {address, data} of the instruction being fetched/held
  logic [IW-1:0] mem [256];
  bit            m_full = 1'b0;  // model holds an unconsumed instruction
  bit            m_err  = 1'b0;  // model has timed out
  int            m_wait = 0;     // cycles the current read has been outstanding

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cond_ok(input logic [2:0] c, input logic [2:0] st);
    bit n, v, z;
    n = st[2]; v = st[1]; z = st[0];
    if (c == 3'd0 || c == 3'd7) return 1'b1;
    if (c == 3'd1) return z;
    if (c == 3'd2) return !z;
    if (c == 3'd3) return n != v;
    if (c == 3'd4) return (n != v) || z;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] entry(input logic [PC_W-1:0] a);
    return {a, mem[a]};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [PC_W-1:0] haddr, nxt, ret;
    logic [IW-1:0]   hdata;
    bit              taken;
    if (reset) begin
      if (exp_q.size() == 0) begin
        chk("queue_nonempty", 32'(exp_q.size()), 32'd1);
      end else begin
        haddr = exp_q[0][W-1:IW];
        hdata = exp_q[0][IW-1:0];
        ret   = haddr + 8'd1;
        taken = m_full && !m_err && ir_ready && br_valid && cond_ok(br_cond, br_status);
        chk("mem_req", {31'd0, mem_req}, {31'd0, !m_full && !m_err});
        chk("ir_valid", {31'd0, ir_valid}, {31'd0, m_full && !m_err});
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("br_taken", {31'd0, br_taken}, {31'd0, taken});
        if (!m_full && !m_err) chk("mem_addr", 32'(mem_addr), 32'(haddr));
        if (m_full && !m_err) begin
          chk("pc", 32'(pc), 32'(haddr));
          chk("ir", 32'(ir), 32'(hdata));
          chk("link", 32'(link), 32'(ret));
        end
        if (!m_err) begin
          if (m_full) begin
            if (ir_ready) begin
              nxt = !taken ? ret : (br_tsel ? br_reg : ret + br_offset);
              void'(exp_q.pop_front());
              exp_q.push_back(entry(nxt));
              m_full = 1'b0;
              m_wait = 0;
            end
          end else if (mem_ack) begin
            m_full = 1'b1;
            m_wait = 0;
          end else begin
            m_wait++;
            if (m_wait > TIMEOUT) m_err = 1'b1;  // issue cycle plus TIMEOUT waiting cycles
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    mem_rdata = mem[mem_addr];
  endtask

  task automatic do_reset(input bit ack);
    mem_ack  = ack;
    ir_ready = 1'b1;
    br_valid = 1'b1;
    br_cond  = 3'd0;
    reset    = 1'b0;
    #1;
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_pc", 32'(pc), 32'(RESET_PC));
    chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_br_taken", {31'd0, br_taken}, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'(RESET_PC));
    exp_q.delete();
    exp_q.push_back(entry(RESET_PC));
    m_full = 1'b0;
    m_err  = 1'b0;
    m_wait = 0;
    tick();
    tick();
    chk("rst_hold_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_hold_ir", 32'(ir), 32'd0);
    br_valid = 1'b0;
    ir_ready = 1'b0;
    reset    = 1'b1;
  endtask

  // Waits for the model to hold an instruction, then consumes it with the given branch.
  task automatic consume(input bit bv, input logic [2:0] c, input logic [2:0] st,
                         input bit ts, input logic [7:0] off, input logic [7:0] rg);
    br_valid = bv; br_cond = c; br_status = st; br_tsel = ts; br_offset = off; br_reg = rg;
    mem_ack  = 1'b1;
    ir_ready = 1'b0;
    for (int i = 0; i < 40 && !m_full; i++) tick();
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    br_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = IW'($urandom);
    mem[0] = 16'hA001;
    #2;
    do_reset(1'b0);

    // Back-to-back fetch with ack and ready held high.
    mem_ack = 1'b1; ir_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    ir_ready = 1'b0;

    // Relative branch taken/not taken from pc 0x10 with offset -2.
    consume(1'b1, 3'b000, 3'b000, 1'b1, 8'h00, 8'h10);
    consume(1'b1, 3'b001, 3'b001, 1'b0, 8'hFE, 8'h00);
    consume(1'b1, 3'b000, 3'b000, 1'b1, 8'h00, 8'h10);
    consume(1'b1, 3'b001, 3'b000, 1'b0, 8'hFE, 8'h00);

    // Register target and an N==V not-taken case.
    consume(1'b1, 3'b000, 3'b000, 1'b1, 8'h00, 8'h42);
    consume(1'b1, 3'b011, 3'b110, 1'b1, 8'h00, 8'h99);

    // Address wrap at 0xFF, with a 5-cycle stall and an ignored branch while held.
    consume(1'b1, 3'b111, 3'b000, 1'b1, 8'h00, 8'hFF);
    br_valid = 1'b1; br_cond = 3'b000; br_tsel = 1'b1; br_reg = 8'h33; mem_ack = 1'b1;
    for (int i = 0; i < 40 && !m_full; i++) tick();
    for (int i = 0; i < 5; i++) tick();
    consume(1'b0, 3'b000, 3'b000, 1'b0, 8'h00, 8'h00);
    consume(1'b0, 3'b000, 3'b000, 1'b0, 8'h00, 8'h00);

    // Memory timeout, late ack ignored, recovery by reset.
    mem_ack = 1'b0; ir_ready = 1'b1;
    for (int i = 0; i < 60 && !m_err; i++) tick();
    for (int i = 0; i < 3; i++) tick();
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    do_reset(1'b0);
    mem_ack = 1'b1; ir_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // Reset in the middle of a wait, coinciding with ack.
    mem_ack = 1'b0; ir_ready = 1'b1;
    for (int i = 0; i < 40 && !(!m_full && m_wait >= 3); i++) tick();
    do_reset(1'b1);
    mem_ack = 1'b0;
    tick();
    tick();

    // Randomized traffic; acks are forced before the timeout can trigger.
    for (int i = 0; i < 600; i++) begin
      tick();
      ir_ready  = ($urandom_range(0, 2) != 0);
      mem_ack   = ($urandom_range(0, 3) != 0) || (m_wait >= 8);
      br_valid  = 1'($urandom_range(0, 1));
      br_cond   = 3'($urandom_range(0, 7));
      br_status = 3'($urandom_range(0, 7));
      br_tsel   = 1'($urandom_range(0, 1));
      br_offset = 8'($urandom_range(0, 255));
      br_reg    = 8'($urandom_range(0, 255));
    end
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
